// File: rtl/game_cmd_sched_if.sv
// Player-command bus for game_cmd_sched: event inputs, flow control and queue head outputs.
// master drives events and pop; slave is the scheduler.
`timescale 1ns/1ps
interface game_cmd_sched_if #(
  parameter int unsigned DEPTH = 8
);
  logic                    enable;
  logic                    flush;
  logic [2:0]              level;
  logic [3:0]              btn;
  logic [3:0]              sw_toggle;
  logic                    rx_valid;
  logic [7:0]              rx_byte;
  logic                    pop;
  logic [3:0]              cmd;
  logic                    cmd_valid;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;

  modport master (
    output enable, flush, level, btn, sw_toggle, rx_valid, rx_byte, pop,
    input  cmd, cmd_valid, count, overflow
  );

  modport slave (
    input  enable, flush, level, btn, sw_toggle, rx_valid, rx_byte, pop,
    output cmd, cmd_valid, count, overflow
  );
endinterface

// File: rtl/game_cmd_sched.sv
// Game command scheduler: buttons, switches, UART (with ANSI arrows) and gravity feed a FWFT queue.
// Define CMD_AUTOREPEAT_EN to build DAS/ARR auto-repeat for the left/right/down buttons.
`timescale 1ns/1ps
module game_cmd_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GRAV_TICK = 50000000,
  parameter int unsigned GRAV_MIN  = 3125000,
  parameter int unsigned DAS_TICK  = 20000000,
  parameter int unsigned ARR_TICK  = 5000000
) (
  input logic             clk,
  input logic             reset_n,
  game_cmd_sched_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NP = 10;

  localparam logic [3:0] CmdNone   = 4'd0;
  localparam logic [3:0] CmdLeft   = 4'd1;
  localparam logic [3:0] CmdRight  = 4'd2;
  localparam logic [3:0] CmdDown   = 4'd3;
  localparam logic [3:0] CmdRotate = 4'd4;
  localparam logic [3:0] CmdRotRev = 4'd5;
  localparam logic [3:0] CmdDrop   = 4'd6;
  localparam logic [3:0] CmdHold   = 4'd7;
  localparam logic [3:0] CmdBar    = 4'd8;

  typedef enum logic [1:0] {StIdle, StEsc, StCsi} esc_e;

  esc_e            esc_q;
  logic [3:0]      btn_q, btn_rise, rpt_fire;
  logic [3:0]      uart_new, uart_code_q, push_code;
  logic [NP-1:0]   pend_q, evt, gnt, taken, keep;
  logic [3:0]      src_code [NP];
  logic            overflow_q, go, push, do_pop, room, grav_fire;
  logic [31:0]     grav_cnt_q, grav_shift, grav_period;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;

  function automatic logic [3:0] plain_code(input logic [7:0] b);
    logic [7:0] u;
    u = b & 8'hDF;
    if (b == 8'h20) return CmdDrop;
    case (u)
      8'h41:   return CmdLeft;
      8'h44:   return CmdRight;
      8'h53:   return CmdDown;
      8'h57:   return CmdDrop;
      8'h43:   return CmdHold;
      8'h58:   return CmdRotate;
      8'h5A:   return CmdRotRev;
      8'h42:   return CmdBar;
      default: return CmdNone;
    endcase
  endfunction

  assign go       = bus.enable && !bus.flush;
  assign btn_rise = bus.btn & ~btn_q;

  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      esc_q <= StIdle;
    end else if (bus.enable && bus.rx_valid) begin
      case (esc_q)
        StIdle:  if (bus.rx_byte == 8'h1B) esc_q <= StEsc;
        StEsc: begin
          if (bus.rx_byte == 8'h5B)      esc_q <= StCsi;
          else if (bus.rx_byte != 8'h1B) esc_q <= StIdle;
        end
        default: esc_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    uart_new = CmdNone;
    if (bus.rx_valid) begin
      case (esc_q)
        StIdle: if (bus.rx_byte != 8'h1B) uart_new = plain_code(bus.rx_byte);
        StEsc: begin
          if (bus.rx_byte != 8'h1B && bus.rx_byte != 8'h5B) uart_new = plain_code(bus.rx_byte);
        end
        default: begin
          case (bus.rx_byte)
            8'h41:   uart_new = CmdRotate;
            8'h42:   uart_new = CmdDown;
            8'h43:   uart_new = CmdRight;
            8'h44:   uart_new = CmdLeft;
            default: uart_new = CmdNone;
          endcase
        end
      endcase
    end
  end

  // Gravity period shrinks with level but never below GRAV_MIN.
  always_comb begin
    grav_shift  = GRAV_TICK >> bus.level;
    grav_period = (grav_shift < GRAV_MIN) ? GRAV_MIN : grav_shift;
  end
  assign grav_fire = grav_cnt_q >= grav_period - 32'd1;

`ifdef CMD_AUTOREPEAT_EN
  logic [31:0] rpt_cnt_q [4];
  logic [3:0]  rpt_arr_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rpt_fire[i] = (i != 2) && go && bus.btn[i] && btn_q[i] &&
                    (rpt_cnt_q[i] == (rpt_arr_q[i] ? ARR_TICK - 32'd1 : DAS_TICK - 32'd1));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n || !go || !(bus.btn[i] && btn_q[i]) || i == 2) begin
        rpt_cnt_q[i] <= '0;
        rpt_arr_q[i] <= 1'b0;
      end else if (rpt_fire[i]) begin
        rpt_cnt_q[i] <= '0;
        rpt_arr_q[i] <= 1'b1;
      end else begin
        rpt_cnt_q[i] <= rpt_cnt_q[i] + 32'd1;
      end
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{DAS_TICK, ARR_TICK};
  assign rpt_fire   = '0;
`endif

  // Slot 0 has the highest priority: UART, sw0..3, btn0..3, gravity.
  always_comb begin
    evt = '0;
    if (go) evt = {grav_fire, btn_rise | rpt_fire, bus.sw_toggle, uart_new != CmdNone};
  end

  always_comb begin
    src_code[0] = uart_code_q;
    src_code[1] = CmdDrop;
    src_code[2] = CmdHold;
    src_code[3] = CmdRotRev;
    src_code[4] = CmdBar;
    src_code[5] = CmdRight;
    src_code[6] = CmdDown;
    src_code[7] = CmdRotate;
    src_code[8] = CmdLeft;
    src_code[9] = CmdDown;
  end

  always_comb begin
    gnt       = '0;
    push_code = CmdNone;
    for (int i = 0; i < NP; i++) begin
      if (pend_q[i] && gnt == '0) begin
        gnt[i]    = 1'b1;
        push_code = src_code[i];
      end
    end
  end

  assign do_pop = bus.pop && (count_q != '0) && !bus.flush;
  assign room   = (count_q != CW'(DEPTH)) || do_pop;
  assign push   = (gnt != '0) && room && go;
  assign taken  = push ? gnt : '0;
  assign keep   = pend_q & ~taken;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q      <= '0;
      overflow_q  <= 1'b0;
      uart_code_q <= CmdNone;
      btn_q       <= '0;
    end else begin
      btn_q <= bus.btn;
      if (bus.flush) begin
        pend_q     <= '0;
        overflow_q <= 1'b0;
      end else if (!bus.enable) begin
        pend_q <= '0;
      end else begin
        pend_q <= keep | evt;
        if (|(keep & evt)) overflow_q <= 1'b1;
        if (evt[0] && !keep[0]) uart_code_q <= uart_new;
      end
    end
  end

  // Gravity's own push must not restart the count, or the period would stretch by one.
  always_ff @(posedge clk) begin
    if (!reset_n || !go) begin
      grav_cnt_q <= '0;
    end else if (grav_fire || (push && push_code == CmdDown && !gnt[9])) begin
      grav_cnt_q <= '0;
    end else begin
      grav_cnt_q <= grav_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push)   wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_code;
  end

  assign bus.cmd       = (count_q != '0) ? mem_q[rd_q] : CmdNone;
  assign bus.cmd_valid = count_q != '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule
